switch_lamp_arbiter: RTL and testbench

- Shares one lamp output L between two bouncy switch requesters, SW0 and SW1.
- Each switch is synchronised and debounced; a round-robin arbiter then grants the lamp to one requester at a time for a fixed hold period.
- Sits between the board switch inputs and the lamp logic driven downstream.

---
 rtl/switch_lamp_arbiter_pkg.sv | 25 ++
 rtl/switch_lamp_arbiter_sw_debounce.sv | 48 ++++
 rtl/switch_lamp_arbiter.sv | 102 ++++++++++
 tb/tb_switch_lamp_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_lamp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// switch_lamp_arbiter_pkg : shared state encoding, defaults and width helper
// Revision 1.0
// ============================================================================
package switch_lamp_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DEB_CYCLES_DEF  = 4;
   localparam int HOLD_CYCLES_DEF = 8;

   // Counter width: clog2 of the larger count, never below 1 bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/switch_lamp_arbiter_sw_debounce.sv
`default_nettype none
// ============================================================================
// sw_debounce : two-flop synchroniser followed by a consecutive-cycle debouncer
// Revision 1.0
// ============================================================================
module sw_debounce
   import switch_lamp_arbiter_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic SW,
   output logic D
);

   localparam int CW = cnt_width(DEB_CYCLES, 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_d;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_d     <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= SW;
         r_sync2 <= r_sync1;
         // Any agreement with the stable level restarts the count.
         if (r_sync2 == r_d) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_d   <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign D = r_d;

endmodule
`default_nettype wire

// File: rtl/switch_lamp_arbiter.sv
`default_nettype none
// ============================================================================
// switch_lamp_arbiter : round-robin lamp sharing between two debounced switches
// Revision 1.0
// ============================================================================
module switch_lamp_arbiter
   import switch_lamp_arbiter_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic SW0,
   input  logic SW1,
   output logic L,
   output logic G0,
   output logic G1,
   output logic D0,
   output logic D1,
   output logic LAST
);

   localparam int TW = cnt_width(DEB_CYCLES, HOLD_CYCLES);

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_g0;
   logic          r_g1;
   logic          r_last;
   logic          w_d0;
   logic          w_d1;
   logic          w_req;
   logic          w_winner;

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
      .CLK (CLK),
      .RST (RST),
      .SW  (SW0),
      .D   (w_d0)
   );

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
      .CLK (CLK),
      .RST (RST),
      .SW  (SW1),
      .D   (w_d1)
   );

   assign w_req    = w_d0 | w_d1;
   // On a tie the channel that did not win last time takes the lamp.
   assign w_winner = (w_d0 & w_d1) ? ~r_last : w_d1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_g0    <= 1'b0;
         r_g1    <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_g0    <= ~w_winner;
                  r_g1    <= w_winner;
                  r_last  <= w_winner;
                  r_timer <= '0;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (r_timer == TW'(HOLD_CYCLES - 1)) begin
                  r_g0    <= 1'b0;
                  r_g1    <= 1'b0;
                  r_timer <= '0;
                  r_state <= GAP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_g0    <= 1'b0;
               r_g1    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign G0   = r_g0;
   assign G1   = r_g1;
   assign L    = r_g0 | r_g1;
   assign D0   = w_d0;
   assign D1   = w_d1;
   assign LAST = r_last;

endmodule
`default_nettype wire

// File: tb/tb_switch_lamp_arbiter.sv
`default_nettype none
// ============================================================================
// tb_switch_lamp_arbiter : directed self-checking bench for switch_lamp_arbiter
// Revision 1.0
// ============================================================================
module tb_switch_lamp_arbiter;

   logic clk;
   logic rst;
   logic sw0;
   logic sw1;
   logic l;
   logic g0;
   logic g1;
   logic d0;
   logic d1;
   logic last;

   int n_checks;
   int n_fail;

   switch_lamp_arbiter #(
      .DEB_CYCLES  (4),
      .HOLD_CYCLES (8)
   ) dut (
      .CLK  (clk),
      .RST  (rst),
      .SW0  (sw0),
      .SW1  (sw1),
      .L    (l),
      .G0   (g0),
      .G1   (g1),
      .D0   (d0),
      .D1   (d1),
      .LAST (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      sw0 = 1'b1;
      sw1 = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({l, g0, g1, d0, d1} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_outs: got L,G0,G1,D0,D1=%b required 00000", {l, g0, g1, d0, d1});
      end
      n_checks++;
      if (last !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_last: got %b required 1", last);
      end
      rst = 1'b0;
      repeat (5) tick();
      n_checks++;
      if ({d0, d1} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_deb_early: got D0,D1=%b required 00 at edge 5", {d0, d1});
      end
      tick();
      n_checks++;
      if ({d0, d1} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_deb_edge6: got D0,D1=%b required 11", {d0, d1});
      end
      tick();
      n_checks++;
      if ({g0, g1, last} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_first_tie: got G0,G1,LAST=%b required 100", {g0, g1, last});
      end
   endtask

   task automatic test_glitch();
      sw0 = 1'b0;
      sw1 = 1'b0;
      apply_reset();
      sw0 = 1'b1;
      repeat (3) tick();
      sw0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (d0 !== 1'b0 || l !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_cycle%0d: got D0=%b L=%b required 0 0", i, d0, l);
         end
         tick();
      end
   endtask

   task automatic test_single();
      sw0 = 1'b0;
      sw1 = 1'b0;
      apply_reset();
      sw0 = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (d0 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_d0_edge5: got %b required 0", d0);
      end
      tick();
      n_checks++;
      if (d0 !== 1'b1 || g0 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_edge6: got D0=%b G0=%b required 1 0", d0, g0);
      end
      tick();
      n_checks++;
      if (g0 !== 1'b1 || l !== 1'b1 || g1 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_grant: got G0=%b L=%b G1=%b required 1 1 0", g0, l, g1);
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++;
         if (l !== 1'b1 || g1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold%0d: got L=%b G1=%b required 1 0", i, l, g1);
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (l !== 1'b0) begin
            n_fail++;
            $display("FAIL single_low%0d: got L=%b required 0", i, l);
         end
      end
      tick();
      n_checks++;
      if (g0 !== 1'b1 || g1 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_regrant: got G0=%b G1=%b required 1 0", g0, g1);
      end
   endtask

   task automatic test_round_robin();
      logic w;
      sw0 = 1'b0;
      sw1 = 1'b0;
      apply_reset();
      sw0 = 1'b1;
      sw1 = 1'b1;
      repeat (6) tick();
      for (int g = 0; g < 4; g++) begin
         w = g[0];
         tick();
         n_checks++;
         if (g0 !== ~w || g1 !== w || last !== w) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got G0=%b G1=%b LAST=%b required %b %b %b",
                     g, g0, g1, last, ~w, w, w);
         end
         for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (l !== 1'b1 || last !== w) begin
               n_fail++;
               $display("FAIL rr_hold%0d_%0d: got L=%b LAST=%b required 1 %b", g, i, l, last, w);
            end
         end
         for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (l !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_gap%0d_%0d: got L=%b required 0", g, i, l);
            end
         end
      end
   endtask

   task automatic test_release_mid();
      sw0 = 1'b0;
      sw1 = 1'b0;
      apply_reset();
      sw0 = 1'b1;
      sw1 = 1'b1;
      repeat (16) tick();
      tick();
      n_checks++;
      if (g1 !== 1'b1 || g0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_g1_grant: got G0=%b G1=%b required 0 1", g0, g1);
      end
      repeat (3) tick();
      sw1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (g1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_g1_hold%0d: got G1=%b required 1", i, g1);
         end
      end
      tick();
      n_checks++;
      if (g1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_g1_end: got G1=%b required 0", g1);
      end
      repeat (2) tick();
      n_checks++;
      if (g0 !== 1'b1 || g1 !== 1'b0 || d1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_next: got G0=%b G1=%b D1=%b required 1 0 0", g0, g1, d1);
      end
      repeat (10) tick();
      n_checks++;
      if (g0 !== 1'b1 || g1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_after: got G0=%b G1=%b required 1 0", g0, g1);
      end
   endtask

   task automatic test_async_reset();
      sw0 = 1'b1;
      sw1 = 1'b0;
      apply_reset();
      repeat (7) tick();
      n_checks++;
      if (g0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ar_pre_grant: got G0=%b required 1", g0);
      end
      repeat (2) tick();
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (l !== 1'b0 || g0 !== 1'b0 || d0 !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_immediate: got L=%b G0=%b D0=%b required 0 0 0", l, g0, d0);
      end
      #2;
      rst = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (d0 !== 1'b0 || g0 !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_edge5: got D0=%b G0=%b required 0 0", d0, g0);
      end
      tick();
      n_checks++;
      if (d0 !== 1'b1 || g0 !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_edge6: got D0=%b G0=%b required 1 0", d0, g0);
      end
      tick();
      n_checks++;
      if (g0 !== 1'b1 || l !== 1'b1) begin
         n_fail++;
         $display("FAIL ar_edge7: got G0=%b L=%b required 1 1", g0, l);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      sw0      = 1'b0;
      sw1      = 1'b0;
      test_reset();
      test_glitch();
      test_single();
      test_round_robin();
      test_release_mid();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
